// File: rtl/e_md_sched_pkg.sv
// Shared definitions for the E-stage multiply/divide scheduler: MD op codes,
// FSM state codes and a start-op classifier used by the scheduler and decoder.
package e_md_sched_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic md_is_start(input logic [3:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage

// File: rtl/e_md_sched_arith.sv
// Combinational multiply/divide datapath: produces the HI/LO pair for a
// mult/div op and flags a zero divisor so the scheduler can skip the commit.
module e_md_arith
  import e_md_sched_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        divz_o
);

  logic [63:0] prod_s_s;
  logic [63:0] prod_u_s;
  logic        bzero_s;
  logic        sovf_s;
  logic [31:0] b_sdiv_s;
  logic [31:0] b_udiv_s;
  logic [31:0] quo_s_s;
  logic [31:0] rem_s_s;
  logic [31:0] quo_u_s;
  logic [31:0] rem_u_s;

  assign bzero_s  = (b_i == 32'd0);
  // Most-negative / -1 is forced through a divide by one: quotient is the dividend, remainder zero.
  assign sovf_s   = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
  assign b_sdiv_s = (bzero_s || sovf_s) ? 32'd1 : b_i;
  assign b_udiv_s = bzero_s ? 32'd1 : b_i;

  assign prod_s_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
  assign prod_u_s = {32'd0, a_i} * {32'd0, b_i};
  assign quo_s_s  = $signed(a_i) / $signed(b_sdiv_s);
  assign rem_s_s  = $signed(a_i) % $signed(b_sdiv_s);
  assign quo_u_s  = a_i / b_udiv_s;
  assign rem_u_s  = a_i % b_udiv_s;

  // Result select by op; non-arithmetic ops yield zero.
  always_comb begin
    hi_o   = 32'd0;
    lo_o   = 32'd0;
    divz_o = 1'b0;
    case (op_i)
      MD_MULT:  {hi_o, lo_o} = prod_s_s;
      MD_MULTU: {hi_o, lo_o} = prod_u_s;
      MD_DIV: begin
        lo_o   = quo_s_s;
        hi_o   = rem_s_s;
        divz_o = bzero_s;
      end
      MD_DIVU: begin
        lo_o   = quo_u_s;
        hi_o   = rem_u_s;
        divz_o = bzero_s;
      end
      default: begin
        hi_o   = 32'd0;
        lo_o   = 32'd0;
        divz_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/e_md_sched.sv
// E-stage multiply/divide scheduler: owns HI/LO, runs mult/div for a fixed
// latency, serves mf*/mt* and raises the D-stage stall on MD collisions.
module e_md_sched
  import e_md_sched_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_MDA,
  input  logic [31:0] E_MDB,
  input  logic        D_IsMD,
  output logic [31:0] E_MDRe,
  output logic        E_MDBusy,
  output logic        E_MDStall
);

  localparam int CW = $clog2(DIV_LAT + 1);
  localparam logic [CW-1:0] MULT_CNT = CW'(MULT_LAT);
  localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_LAT);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d;
  logic [31:0]   pend_lo_q, pend_lo_d;
  logic          pend_wr_q, pend_wr_d;

  logic          start_s;
  logic          is_div_s;
  logic [31:0]   ar_hi_s;
  logic [31:0]   ar_lo_s;
  logic          ar_divz_s;

  e_md_arith u_arith (
    .op_i   (E_MDOp),
    .a_i    (E_MDA),
    .b_i    (E_MDB),
    .hi_o   (ar_hi_s),
    .lo_o   (ar_lo_s),
    .divz_o (ar_divz_s)
  );

  assign start_s  = md_is_start(E_MDOp);
  assign is_div_s = (E_MDOp == MD_DIV) || (E_MDOp == MD_DIVU);

  // FSM next state, HI/LO writes and pending-result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d   = ST_RUN;
          cnt_d     = is_div_s ? DIV_CNT : MULT_CNT;
          pend_hi_d = ar_hi_s;
          pend_lo_d = ar_lo_s;
          pend_wr_d = ~ar_divz_s;
        end else if (E_MDOp == MD_MTHI) begin
          hi_d = E_MDA;
        end else if (E_MDOp == MD_MTLO) begin
          lo_d = E_MDA;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          // A zero divisor still burns the full latency but leaves HI/LO untouched.
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end else begin
            hi_d = hi_q;
            lo_d = lo_q;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and data registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign E_MDBusy  = (state_q == ST_RUN);
  assign E_MDStall = D_IsMD & (start_s | E_MDBusy);
  assign E_MDRe    = (E_MDOp == MD_MFHI) ? hi_q :
                     (E_MDOp == MD_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_e_md_sched.sv
// Directed self-checking bench for e_md_sched: latency, arithmetic results,
// mt*/mf* access, stall timing and reset during a running divide.
module tb_e_md_sched;
  import e_md_sched_pkg::*;

  localparam int MLAT = 5;
  localparam int DLAT = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  E_MDOp = 4'd0;
  logic [31:0] E_MDA = 32'd0;
  logic [31:0] E_MDB = 32'd0;
  logic        D_IsMD = 1'b0;
  logic [31:0] E_MDRe;
  logic        E_MDBusy;
  logic        E_MDStall;

  int total = 0;
  int bad = 0;

  e_md_sched #(.MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .E_MDOp    (E_MDOp),
    .E_MDA     (E_MDA),
    .E_MDB     (E_MDB),
    .D_IsMD    (D_IsMD),
    .E_MDRe    (E_MDRe),
    .E_MDBusy  (E_MDBusy),
    .E_MDStall (E_MDStall)
  );

  always #5 clk = ~clk;

  // The stall protocol must keep MD ops out of E while the unit runs.
  always @(posedge clk) begin
    if (!reset && E_MDBusy && (md_is_start(E_MDOp) || E_MDOp == MD_MTHI || E_MDOp == MD_MTLO)) begin
      bad++;
      $display("FAIL op_during_run: op=%0d issued while busy, required none", E_MDOp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] op, output logic [31:0] v);
    E_MDOp = op;
    #1;
    v = E_MDRe;
    E_MDOp = MD_NONE;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    D_IsMD = 1'b1;
    tick();
    tick();
    total++; if (E_MDBusy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", E_MDBusy); end
    total++; if (E_MDStall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", E_MDStall); end
    rd(MD_MFHI, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", v); end
    rd(MD_MFLO, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", v); end
    reset = 1'b0;
    D_IsMD = 1'b0;
    tick();
  endtask

  task automatic test_mult();
    logic [3:0]  ops [2] = '{MD_MULT, MD_MULTU};
    logic [31:0] exp_hi [2] = '{32'hFFFF_FFFF, 32'h0000_0002};
    logic [31:0] v;
    for (int t = 0; t < 2; t++) begin
      D_IsMD = 1'b1;
      E_MDOp = ops[t]; E_MDA = 32'hFFFF_FFFE; E_MDB = 32'd3;
      #1;
      total++; if (E_MDStall !== 1'b1) begin bad++; $display("FAIL mult_start_stall[%0d]: got %b want 1", t, E_MDStall); end
      total++; if (E_MDBusy !== 1'b0) begin bad++; $display("FAIL mult_start_busy[%0d]: got %b want 0", t, E_MDBusy); end
      tick();
      E_MDOp = MD_NONE;
      #1;
      for (int k = 0; k < MLAT; k++) begin
        total++; if (E_MDBusy !== 1'b1) begin bad++; $display("FAIL mult_busy[%0d] cyc %0d: got %b want 1", t, k + 1, E_MDBusy); end
        total++; if (E_MDStall !== 1'b1) begin bad++; $display("FAIL mult_stall[%0d] cyc %0d: got %b want 1", t, k + 1, E_MDStall); end
        tick();
      end
      total++; if (E_MDBusy !== 1'b0) begin bad++; $display("FAIL mult_done_busy[%0d]: got %b want 0", t, E_MDBusy); end
      total++; if (E_MDStall !== 1'b0) begin bad++; $display("FAIL mult_done_stall[%0d]: got %b want 0", t, E_MDStall); end
      rd(MD_MFHI, v);
      total++; if (v !== exp_hi[t]) begin bad++; $display("FAIL mult_hi[%0d]: got %h want %h", t, v, exp_hi[t]); end
      rd(MD_MFLO, v);
      total++; if (v !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_lo[%0d]: got %h want fffffffa", t, v); end
      D_IsMD = 1'b0;
    end
  endtask

  task automatic test_div();
    logic [3:0]  ops [5]    = '{MD_DIV, MD_DIVU, MD_DIV, MD_DIV, MD_DIVU};
    logic [31:0] as [5]     = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9};
    logic [31:0] bs [5]     = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd2};
    logic [31:0] exp_hi [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h1};
    logic [31:0] exp_lo [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFD, 32'h7FFF_FFFC};
    logic [31:0] v;
    D_IsMD = 1'b0;
    for (int t = 0; t < 5; t++) begin
      E_MDOp = ops[t]; E_MDA = as[t]; E_MDB = bs[t];
      #1;
      total++; if (E_MDStall !== 1'b0) begin bad++; $display("FAIL div_start_stall[%0d]: got %b want 0", t, E_MDStall); end
      tick();
      E_MDOp = MD_NONE;
      #1;
      for (int k = 0; k < DLAT; k++) begin
        total++; if (E_MDBusy !== 1'b1 || E_MDStall !== 1'b0) begin
          bad++; $display("FAIL div_busy[%0d] cyc %0d: busy=%b stall=%b want busy=1 stall=0", t, k + 1, E_MDBusy, E_MDStall);
        end
        tick();
      end
      total++; if (E_MDBusy !== 1'b0) begin bad++; $display("FAIL div_done_busy[%0d]: got %b want 0", t, E_MDBusy); end
      rd(MD_MFHI, v);
      total++; if (v !== exp_hi[t]) begin bad++; $display("FAIL div_hi[%0d]: got %h want %h", t, v, exp_hi[t]); end
      rd(MD_MFLO, v);
      total++; if (v !== exp_lo[t]) begin bad++; $display("FAIL div_lo[%0d]: got %h want %h", t, v, exp_lo[t]); end
    end
  endtask

  task automatic test_mt();
    logic [31:0] v;
    D_IsMD = 1'b1;
    E_MDOp = MD_MTHI; E_MDA = 32'h0000_1234;
    #1;
    total++; if (E_MDStall !== 1'b0) begin bad++; $display("FAIL mthi_stall: got %b want 0", E_MDStall); end
    tick();
    E_MDOp = MD_MTLO; E_MDA = 32'h0000_5678;
    #1;
    total++; if (E_MDBusy !== 1'b0) begin bad++; $display("FAIL mthi_busy: got %b want 0", E_MDBusy); end
    rd(MD_MFHI, v);
    total++; if (v !== 32'h0000_1234) begin bad++; $display("FAIL mfhi: got %h want 00001234", v); end
    E_MDOp = MD_MTLO;
    tick();
    E_MDOp = MD_NONE;
    #1;
    rd(MD_MFLO, v);
    total++; if (v !== 32'h0000_5678) begin bad++; $display("FAIL mflo: got %h want 00005678", v); end
    total++; if (E_MDBusy !== 1'b0 || E_MDStall !== 1'b0) begin
      bad++; $display("FAIL mt_idle: busy=%b stall=%b want 0 0", E_MDBusy, E_MDStall);
    end
    rd(MD_MFHI, v);
    total++; if (v !== 32'h0000_1234) begin bad++; $display("FAIL mfhi_kept: got %h want 00001234", v); end
    D_IsMD = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [31:0] v;
    E_MDOp = MD_DIV; E_MDA = 32'd100; E_MDB = 32'd3;
    tick();
    E_MDOp = MD_NONE;
    tick();
    tick();
    total++; if (E_MDBusy !== 1'b1) begin bad++; $display("FAIL midrun_busy: got %b want 1", E_MDBusy); end
    reset = 1'b1;
    #1;
    total++; if (E_MDBusy !== 1'b0) begin bad++; $display("FAIL midrun_reset_busy: got %b want 0", E_MDBusy); end
    rd(MD_MFHI, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL midrun_reset_hi: got %h want 0", v); end
    rd(MD_MFLO, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL midrun_reset_lo: got %h want 0", v); end
    tick();
    reset = 1'b0;
    tick();
    D_IsMD = 1'b1;
    E_MDOp = MD_MULT; E_MDA = 32'd6; E_MDB = 32'd7;
    tick();
    E_MDOp = MD_NONE;
    #1;
    for (int k = 0; k < MLAT; k++) begin
      total++; if (E_MDBusy !== 1'b1) begin bad++; $display("FAIL post_reset_busy cyc %0d: got %b want 1", k + 1, E_MDBusy); end
      tick();
    end
    total++; if (E_MDBusy !== 1'b0 || E_MDStall !== 1'b0) begin
      bad++; $display("FAIL post_reset_done: busy=%b stall=%b want 0 0", E_MDBusy, E_MDStall);
    end
    rd(MD_MFHI, v);
    total++; if (v !== 32'd0) begin bad++; $display("FAIL post_reset_hi: got %h want 0", v); end
    rd(MD_MFLO, v);
    total++; if (v !== 32'd42) begin bad++; $display("FAIL post_reset_lo: got %h want 0000002a", v); end
    D_IsMD = 1'b0;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_reset_midrun();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
